// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back stage: load alignment/extension, result select,
// regfile write port and trace pc. Optional retired-instruction counter under WB_INSTRET_EN.
module wb_stage #(
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               stall,
    input  logic               flush,
    input  logic               m_valid,
    input  logic [ADDR_W-1:0]  m_pc,
    input  logic [RFIDX_W-1:0] m_rd,
    input  logic               m_regwrite,
    input  logic [1:0]         m_wbsel,
    input  logic [2:0]         m_funct3,
    input  logic [XLEN-1:0]    m_aluout,
    input  logic [XLEN-1:0]    m_rdata,
    output logic               we3,
    output logic [RFIDX_W-1:0] wa3,
    output logic [XLEN-1:0]    wd3,
    output logic [ADDR_W-1:0]  wb_pc,
    output logic               wb_valid,
    output logic [63:0]        instret
);

    typedef enum logic [1:0] {
        WBSEL_ALU  = 2'b00,
        WBSEL_LOAD = 2'b01,
        WBSEL_PC4  = 2'b10,
        WBSEL_RSVD = 2'b11
    } wbsel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic               valid_q;
    logic               regwrite_q;
    logic               done_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [RFIDX_W-1:0] rd_q;
    logic [1:0]         wbsel_q;
    logic [2:0]         funct3_q;
    logic [XLEN-1:0]    aluout_q;
    logic [XLEN-1:0]    rdata_q;

    // Stage contract: flush beats stall beats advance at each posedge. An instruction in WB
    // is presented to the regfile exactly once; done_q marks that the write already happened
    // while a stall keeps the instruction parked here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            done_q     <= 1'b0;
            pc_q       <= '0;
            rd_q       <= '0;
            wbsel_q    <= '0;
            funct3_q   <= '0;
            aluout_q   <= '0;
            rdata_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (stall) begin
            if (valid_q) begin
                done_q <= 1'b1;
            end
        end else begin
            valid_q    <= m_valid;
            regwrite_q <= m_regwrite;
            done_q     <= 1'b0;
            pc_q       <= m_pc;
            rd_q       <= m_rd;
            wbsel_q    <= m_wbsel;
            funct3_q   <= m_funct3;
            aluout_q   <= m_aluout;
            rdata_q    <= m_rdata;
        end
    end

    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   ld_data;
    logic [ADDR_W-1:0] pc_plus4;

    // Memory returns a word-aligned read; the low address bits pick the lane.
    always_comb begin
        ld_byte = rdata_q[7:0];
        case (aluout_q[1:0])
            2'd0:    ld_byte = rdata_q[7:0];
            2'd1:    ld_byte = rdata_q[15:8];
            2'd2:    ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase
        ld_half = aluout_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    end

    always_comb begin
        ld_data = rdata_q;
        case (funct3_q)
            F3_LB:   ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            F3_LH:   ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = rdata_q;
        endcase
    end

    assign pc_plus4 = pc_q + ADDR_W'(4);

    always_comb begin
        wd3 = aluout_q;
        case (wbsel_e'(wbsel_q))
            WBSEL_ALU:  wd3 = aluout_q;
            WBSEL_LOAD: wd3 = ld_data;
            WBSEL_PC4:  wd3 = XLEN'(pc_plus4);
            WBSEL_RSVD: wd3 = aluout_q;
            default:    wd3 = aluout_q;
        endcase
    end

    assign we3      = valid_q & regwrite_q & (rd_q != '0) & ~done_q;
    assign wa3      = rd_q;
    assign wb_pc    = pc_q;
    assign wb_valid = valid_q;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    // An instruction retires when it leaves WB; a flush on that edge does not undo it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            instret_q <= '0;
        end else if (valid_q && !stall) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: reset, ALU/load/PC+4 results, stall/flush,
// rd=0, reset mid-stall and instret; regfile model with an expected-write queue.
module tb_wb_stage;

    logic        clk;
    logic        rstn;
    logic        stall;
    logic        flush;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [4:0]  m_rd;
    logic        m_regwrite;
    logic [1:0]  m_wbsel;
    logic [2:0]  m_funct3;
    logic [31:0] m_aluout;
    logic [31:0] m_rdata;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [31:0] wb_pc;
    logic        wb_valid;
    logic [63:0] instret;

    int checks   = 0;
    int failures = 0;

    logic [36:0] exp_q[$];
    logic [31:0] rf[32];

    wb_stage dut (
        .clk        (clk),
        .rstn       (rstn),
        .stall      (stall),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_pc       (m_pc),
        .m_rd       (m_rd),
        .m_regwrite (m_regwrite),
        .m_wbsel    (m_wbsel),
        .m_funct3   (m_funct3),
        .m_aluout   (m_aluout),
        .m_rdata    (m_rdata),
        .we3        (we3),
        .wa3        (wa3),
        .wd3        (wd3),
        .wb_pc      (wb_pc),
        .wb_valid   (wb_valid),
        .instret    (instret)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                         input logic rw, input logic [1:0] sel, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rdat);
        m_valid    = v;
        m_pc       = pc;
        m_rd       = rd;
        m_regwrite = rw;
        m_wbsel    = sel;
        m_funct3   = f3;
        m_aluout   = alu;
        m_rdata    = rdat;
    endtask

    task automatic drive_idle();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic expect_write(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back({rd, data});
    endtask

    // Regfile model: commits on the negedge of the write cycle; every write must be expected.
    always @(negedge clk) begin
        if (we3 === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_we3", {63'd0, we3}, 64'd0);
            end else begin
                check("rf_write", {27'd0, wa3, wd3}, {27'd0, exp_q.pop_front()});
            end
            rf[wa3] = wd3;
        end
    end

    logic [2:0]  ld_f3[11];
    logic [31:0] ld_alu[11];
    logic [31:0] ld_exp[11];

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rstn  = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive_idle();

        // reset state, observed before any clock edge
        #3;
        check("rst_we3", {63'd0, we3}, 64'd0);
        check("rst_wa3", {59'd0, wa3}, 64'd0);
        check("rst_wd3", {32'd0, wd3}, 64'd0);
        check("rst_wb_pc", {32'd0, wb_pc}, 64'd0);
        check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("rst_instret", instret, 64'd0);
        #9;
        rstn = 1'b1;

        // ALU result
        drive(1'b1, 32'h100, 5'd5, 1'b1, 2'b00, 3'b000, 32'h1234, 32'h0);
        expect_write(5'd5, 32'h1234);
        step();
        check("alu_we3", {63'd0, we3}, 64'd1);
        check("alu_wa3", {59'd0, wa3}, 64'd5);
        check("alu_wd3", {32'd0, wd3}, 64'h1234);
        check("alu_wb_pc", {32'd0, wb_pc}, 64'h100);
        drive_idle();
        step();
        check("alu_idle_we3", {63'd0, we3}, 64'd0);
        check("alu_rf_x5", {32'd0, rf[5]}, 64'h1234);

        // loads from rdata=0x80FF7F01 (bytes 01,7F,FF,80 from lane 0 up)
        ld_f3  = '{3'b000, 3'b100, 3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b001,
                   3'b001, 3'b010, 3'b011};
        ld_alu = '{32'h1001, 32'h1001, 32'h1002, 32'h1002, 32'h1003, 32'h1002, 32'h1002,
                   32'h1003, 32'h1000, 32'h1003, 32'h1000};
        ld_exp = '{32'h0000007F, 32'h0000007F, 32'hFFFFFFFF, 32'h000000FF, 32'hFFFFFF80,
                   32'hFFFF80FF, 32'h000080FF, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01,
                   32'h80FF7F01};
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 32'h200 + 32'(i * 4), 5'd12, 1'b1, 2'b01, ld_f3[i], ld_alu[i],
                  32'h80FF7F01);
            expect_write(5'd12, ld_exp[i]);
            step();
            check($sformatf("load%0d_wd3", i), {32'd0, wd3}, {32'd0, ld_exp[i]});
        end

        // PC+4, wrap and reserved select
        drive(1'b1, 32'hFFFFFFFC, 5'd13, 1'b1, 2'b10, 3'b000, 32'h5555, 32'h0);
        expect_write(5'd13, 32'h0);
        step();
        check("pc4_wrap_wd3", {32'd0, wd3}, 64'h0);
        drive(1'b1, 32'h00000100, 5'd13, 1'b1, 2'b10, 3'b000, 32'h5555, 32'h0);
        expect_write(5'd13, 32'h104);
        step();
        check("pc4_wd3", {32'd0, wd3}, 64'h104);
        drive(1'b1, 32'h00000104, 5'd14, 1'b1, 2'b11, 3'b000, 32'hBEEF, 32'h0);
        expect_write(5'd14, 32'hBEEF);
        step();
        check("rsvd_sel_wd3", {32'd0, wd3}, 64'hBEEF);

        // stall: one write, fields held, new MEM instruction not captured
        drive(1'b1, 32'h300, 5'd7, 1'b1, 2'b00, 3'b000, 32'hAAAA, 32'h0);
        expect_write(5'd7, 32'hAAAA);
        step();
        check("stall_first_we3", {63'd0, we3}, 64'd1);
        stall = 1'b1;
        drive(1'b1, 32'h304, 5'd8, 1'b1, 2'b00, 3'b000, 32'hBBBB, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall%0d_we3", k), {63'd0, we3}, 64'd0);
            check($sformatf("stall%0d_hold", k), {27'd0, wa3, wd3}, {27'd0, 5'd7, 32'hAAAA});
            check($sformatf("stall%0d_valid", k), {63'd0, wb_valid}, 64'd1);
        end
        stall = 1'b0;
        expect_write(5'd8, 32'hBBBB);
        step();
        check("unstall_wa3", {59'd0, wa3}, 64'd8);
        check("unstall_we3", {63'd0, we3}, 64'd1);
        stall = 1'b1;
        flush = 1'b1;
        drive_idle();
        step();
        check("flush_stall_valid", {63'd0, wb_valid}, 64'd0);
        check("flush_stall_we3", {63'd0, we3}, 64'd0);
        stall = 1'b0;
        flush = 1'b0;

        // rd=0 retires without writing
        drive(1'b1, 32'h400, 5'd0, 1'b1, 2'b00, 3'b000, 32'hDEAD, 32'h0);
        step();
        check("rd0_we3", {63'd0, we3}, 64'd0);
        check("rd0_valid", {63'd0, wb_valid}, 64'd1);
        drive_idle();
        step();
        check("rd0_rf_x0", {32'd0, rf[0]}, 64'd0);

        // reset while stalled
        drive(1'b1, 32'h500, 5'd10, 1'b1, 2'b00, 3'b000, 32'h55, 32'h0);
        expect_write(5'd10, 32'h55);
        step();
        check("rstmid_we3", {63'd0, we3}, 64'd1);
        stall = 1'b1;
        drive(1'b1, 32'h504, 5'd11, 1'b1, 2'b00, 3'b000, 32'h66, 32'h0);
        step();
        check("rstmid_stalled_we3", {63'd0, we3}, 64'd0);
        #2;
        rstn = 1'b0;
        #1;
        check("rstmid_valid", {63'd0, wb_valid}, 64'd0);
        check("rstmid_wa3", {59'd0, wa3}, 64'd0);
        check("rstmid_wd3", {32'd0, wd3}, 64'd0);
        check("rstmid_wb_pc", {32'd0, wb_pc}, 64'd0);
        check("rstmid_instret", instret, 64'd0);
        step();
        rstn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("post_rst%0d_we3", k), {63'd0, we3}, 64'd0);
            check($sformatf("post_rst%0d_valid", k), {63'd0, wb_valid}, 64'd0);
        end
        stall = 1'b0;
        drive_idle();
        step();

        // ten instructions, two of them stalled for two cycles in WB
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h600 + 32'(i * 4), 5'(20 + i), 1'b1, 2'b00, 3'b000,
                  32'h1000 + 32'(i), 32'h0);
            expect_write(5'(20 + i), 32'h1000 + 32'(i));
            step();
            if (i == 3 || i == 7) begin
                stall = 1'b1;
                step();
                step();
                check($sformatf("ir_stall%0d_we3", i), {63'd0, we3}, 64'd0);
                stall = 1'b0;
            end
        end
        drive_idle();
        step();
        step();
`ifdef WB_INSTRET_EN
        check("instret_10", instret, 64'd10);
`else
        check("instret_tied0", instret, 64'd0);
`endif
        check("rf_x29", {32'd0, rf[29]}, 64'h1009);
        check("pending_writes", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
